// File: rtl/mul_if.sv
// ---------------------------------------------------------------------------
// mul_if
// Handshake and data bundle between the RSA stage controller and the
// sequential multiplier.  The controller drives the master side, the
// multiplier implements the slave side.
//
// Signals:
//   enable     block enable; low aborts and blocks new requests
//   req        request toggle; any level change starts an operation
//   rx_data_1  multiplicand A (MSB+1 bits)
//   rx_data_2  multiplier B (MSB+1 bits)
//   tx_data    registered product A*B (2*(MSB+1) bits)
//   ack        one-cycle pulse while tx_data is freshly valid
//   cst        current state
//   nst        next state (combinational)
// ---------------------------------------------------------------------------
interface mul_if #(
    parameter int MSB = 7
);
    logic               enable;
    logic               req;
    logic [MSB:0]       rx_data_1;
    logic [MSB:0]       rx_data_2;
    logic [2*MSB+1:0]   tx_data;
    logic               ack;
    logic [1:0]         cst;
    logic [1:0]         nst;

    modport master (
        output enable, req, rx_data_1, rx_data_2,
        input  tx_data, ack, cst, nst
    );

    modport slave (
        input  enable, req, rx_data_1, rx_data_2,
        output tx_data, ack, cst, nst
    );
endinterface

// File: rtl/mul.sv
// ---------------------------------------------------------------------------
// mul
// Sequential radix-2 shift-add multiplier for the RSA datapath.  It feeds
// the remainder stage and shares its toggle-request / pulse-acknowledge
// handshake, enable gating and exposed state, so both stages can be driven
// by one controller.  One multiplier bit is consumed per clock.
//
// Ports:
//   clk   single clock, all state changes on the rising edge
//   rstn  asynchronous active-low reset
//   bus   mul_if slave: enable, req, rx_data_1, rx_data_2 in;
//         tx_data, ack, cst, nst out
//
// Configuration:
//   MUL_ZERO_BYPASS_EN  when defined, a zero operand skips the iteration
//                       phase and finishes straight from LOAD with a zero
//                       product.  Results are identical in both builds.
// ---------------------------------------------------------------------------
module mul #(
    parameter int MSB = 7
) (
    input  logic  clk,
    input  logic  rstn,
    mul_if.slave  bus
);
    localparam int W  = MSB + 1;
    localparam int CW = $clog2(W) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             r_cst;
    state_t             w_nst;
    logic               r_reqQ;
    logic [2*W:0]       r_p;
    logic [W-1:0]       r_a;
    logic [CW-1:0]      r_cnt;
    logic [2*W-1:0]     r_tx;
    logic               r_ack;

    logic [W:0]         w_upperSum;
    logic [2*W:0]       w_pNext;
    logic               w_zeroOp;

    // One shift-add step: the upper half gains A when the current multiplier
    // bit (P[0]) is set; the sum keeps its carry in bit 2W before the whole
    // register shifts right, so no product bit is ever lost.
    always_comb begin
        w_upperSum = r_p[2*W:W] + (r_p[0] ? {1'b0, r_a} : {(W+1){1'b0}});
        w_pNext    = {w_upperSum, r_p[W-1:0]} >> 1;
    end

    // Zero-operand detection, only meaningful when the bypass is built in.
`ifdef MUL_ZERO_BYPASS_EN
    assign w_zeroOp = (bus.rx_data_1 == '0) || (bus.rx_data_2 == '0);
`else
    assign w_zeroOp = 1'b0;
`endif

    // Next-state decode.  Enable low always forces IDLE; a request is seen
    // only in IDLE as a difference between req and the last accepted level.
    always_comb begin
        w_nst = r_cst;
        if (!bus.enable) begin
            w_nst = IDLE;
        end else begin
            case (r_cst)
                IDLE:    if (bus.req != r_reqQ) w_nst = LOAD;
                LOAD:    w_nst = w_zeroOp ? DONE : CALC;
                CALC:    if (r_cnt == LAST_ITER) w_nst = DONE;
                DONE:    w_nst = IDLE;
                default: w_nst = IDLE;
            endcase
        end
    end

    // State, datapath and registered outputs.  ack is cleared every cycle
    // and set only on the edge entering DONE, which makes it a single-cycle
    // pulse.  While disabled, req_q follows req so toggles are dropped
    // rather than queued.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cst  <= IDLE;
            r_reqQ <= 1'b0;
            r_p    <= '0;
            r_a    <= '0;
            r_cnt  <= '0;
            r_tx   <= '0;
            r_ack  <= 1'b0;
        end else begin
            r_cst <= w_nst;
            r_ack <= 1'b0;
            if (!bus.enable) begin
                r_reqQ <= bus.req;
            end else begin
                case (r_cst)
                    IDLE: begin
                        if (w_nst == LOAD) r_reqQ <= bus.req;
                    end
                    LOAD: begin
                        r_a   <= bus.rx_data_1;
                        r_p   <= {{(W+1){1'b0}}, bus.rx_data_2};
                        r_cnt <= '0;
                        if (w_zeroOp) begin
                            r_tx  <= '0;
                            r_ack <= 1'b1;
                        end
                    end
                    CALC: begin
                        r_p   <= w_pNext;
                        r_cnt <= r_cnt + 1'b1;
                        // Bit 2W of the final P is always zero, so the low
                        // 2W bits carry the complete product.
                        if (w_nst == DONE) begin
                            r_tx  <= w_pNext[2*W-1:0];
                            r_ack <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.tx_data = r_tx;
    assign bus.ack     = r_ack;
    assign bus.cst     = r_cst;
    assign bus.nst     = w_nst;

endmodule

// File: tb/tb_mul.sv
// ---------------------------------------------------------------------------
// tb_mul
// Self-checking bench for the sequential multiplier.  A timeline model
// predicts, from the edge on which each request is accepted, when the
// result appears, which phase the block is in and what product it must
// deliver; a compare process checks every cycle against it.  Directed
// scenarios pin the model with hand-computed values, then randomized
// operand pairs run with one reset pulse in the middle of an operation.
// ---------------------------------------------------------------------------
module tb_mul;
    localparam int MSB = 7;
    localparam int W   = MSB + 1;
`ifdef MUL_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    always #5 clk = ~clk;

    mul_if #(.MSB(MSB)) busIf ();

    mul #(.MSB(MSB)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (busIf)
    );

    int checksTotal  = 0;
    int checksPassed = 0;
    int ackSeen      = 0;

    // Timeline model: an accepted request at edge k captures operands at
    // edge k+1 and delivers A*B at edge k+W+1 (k+1 for a bypassed zero
    // operand); the block is idle again one edge later.
    bit               mActive  = 1'b0;
    logic             mReqQ    = 1'b0;
    int               mEdge    = 0;
    int               mStart   = 0;
    int               mAckEdge = -10;
    logic [2*W-1:0]   mA       = '0;
    logic [2*W-1:0]   mB       = '0;
    logic [2*W-1:0]   mTx      = '0;
    logic             mAck     = 1'b0;
    logic [1:0]       mCst     = 2'd0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checksTotal++;
        if (actual === expected) checksPassed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Model update on every rising edge, asynchronously cleared by reset.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mActive = 1'b0;
            mReqQ   = 1'b0;
            mTx     = '0;
            mAck    = 1'b0;
            mCst    = 2'd0;
        end else begin
            mEdge++;
            mAck = 1'b0;
            if (busIf.enable !== 1'b1) begin
                mActive = 1'b0;
                mReqQ   = busIf.req;
                mCst    = 2'd0;
            end else if (!mActive) begin
                if (busIf.req !== mReqQ) begin
                    mActive = 1'b1;
                    mStart  = mEdge;
                    mReqQ   = busIf.req;
                    mCst    = 2'd1;
                end else begin
                    mCst = 2'd0;
                end
            end else begin
                if (mEdge == mStart + 1) begin
                    mA = {{W{1'b0}}, busIf.rx_data_1};
                    mB = {{W{1'b0}}, busIf.rx_data_2};
                    mAckEdge = (BYPASS && (mA == 0 || mB == 0)) ? mStart + 1 : mStart + W + 1;
                end
                if (mEdge == mAckEdge) begin
                    mTx  = mA * mB;
                    mAck = 1'b1;
                    mCst = 2'd3;
                end else if (mEdge == mAckEdge + 1) begin
                    mActive = 1'b0;
                    mCst    = 2'd0;
                end else begin
                    mCst = 2'd2;
                end
            end
        end
    end

    // Count every ack cycle the DUT shows.
    always @(negedge clk) begin
        if (busIf.ack === 1'b1) ackSeen++;
    end

    // Per-cycle comparison against the model, sampled mid-low-phase.
    initial begin : compareProc
        logic [1:0] expNst;
        forever begin
            @(negedge clk);
            #2;
            if (busIf.enable !== 1'b1) expNst = 2'd0;
            else begin
                case (mCst)
                    2'd0:    expNst = (busIf.req !== mReqQ) ? 2'd1 : 2'd0;
                    2'd1:    expNst = (BYPASS && (busIf.rx_data_1 == 0 || busIf.rx_data_2 == 0))
                                      ? 2'd3 : 2'd2;
                    2'd2:    expNst = (mEdge + 1 == mAckEdge) ? 2'd3 : 2'd2;
                    default: expNst = 2'd0;
                endcase
            end
            checkOutput("cst", busIf.cst, mCst);
            checkOutput("nst", busIf.nst, expNst);
            checkOutput("ack", busIf.ack, mAck);
            checkOutput("tx_data", busIf.tx_data, mTx);
        end
    end

    // Present operands and toggle the request on a falling edge.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        busIf.rx_data_1 = a;
        busIf.rx_data_2 = b;
        busIf.req       = ~busIf.req;
    endtask

    // Run one operation; lat is the number of rising edges from the toggle
    // up to the cycle showing ack (0 on timeout).  Optionally scrambles the
    // operand inputs once they have been captured.
    task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input bit scramble,
                         output int lat, output logic [2*W-1:0] prod);
        applyStimulus(a, b);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            #1;
            if (busIf.ack === 1'b1) begin
                lat = n;
                break;
            end
            if (scramble && n == 2) begin
                busIf.rx_data_1 = W'($urandom());
                busIf.rx_data_2 = W'($urandom());
            end
        end
        if (lat == 0) checkOutput("ackTimeout", 0, 1);
        prod = busIf.tx_data;
        @(negedge clk);
    endtask

    function automatic int expLatency(input logic [W-1:0] a, input logic [W-1:0] b);
        return (BYPASS && (a == 0 || b == 0)) ? 2 : W + 2;
    endfunction

    initial begin : mainProc
        int             lat;
        int             base;
        int             sel;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] prod;
        logic [2*W-1:0] expProd;

        busIf.enable    = 1'b0;
        busIf.req       = 1'b0;
        busIf.rx_data_1 = '0;
        busIf.rx_data_2 = '0;

        // Reset held for 10 cycles while req toggles underneath it.
        repeat (10) begin
            @(negedge clk);
            busIf.req    = ~busIf.req;
            busIf.enable = 1'b1;
        end
        #1;
        checkOutput("resetCst", busIf.cst, 2'd0);
        checkOutput("resetAck", busIf.ack, 1'b0);
        checkOutput("resetTx", busIf.tx_data, 16'h0000);
        checkOutput("resetNoAck", ackSeen, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        checkOutput("idleNst", busIf.nst, 2'd0);

        // Zero operand.
        runOp(8'h00, 8'h5A, 1'b0, lat, prod);
        checkOutput("zeroProd", prod, 16'h0000);
        checkOutput("zeroLat", lat, BYPASS ? 2 : 10);

        // Maximum operands, with a single-cycle ack.
        base = ackSeen;
        runOp(8'hFF, 8'hFF, 1'b0, lat, prod);
        checkOutput("maxProd", prod, 16'hFE01);
        checkOutput("maxLat", lat, 10);
        #1;
        checkOutput("maxAckPulse", busIf.ack, 1'b0);
        checkOutput("maxAckCount", ackSeen - base, 1);

        // Abort by dropping enable in the middle of the iterations.
        base = ackSeen;
        applyStimulus(8'h37, 8'h21);
        repeat (4) @(negedge clk);
        #1;
        checkOutput("abortInCalc", busIf.cst, 2'd2);
        busIf.enable = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("abortCst", busIf.cst, 2'd0);
        checkOutput("abortTx", busIf.tx_data, 16'hFE01);
        busIf.req = ~busIf.req;
        repeat (3) @(negedge clk);
        busIf.enable = 1'b1;
        repeat (W + 4) @(negedge clk);
        #1;
        checkOutput("abortDroppedToggle", busIf.cst, 2'd0);
        checkOutput("abortNoAck", ackSeen - base, 0);
        runOp(8'd13, 8'd11, 1'b0, lat, prod);
        checkOutput("afterAbortProd", prod, 16'd143);

        // One extra toggle while busy queues exactly one more operation.
        base = ackSeen;
        applyStimulus(8'd200, 8'd3);
        repeat (3) @(negedge clk);
        busIf.req = ~busIf.req;
        repeat (3 * (W + 3)) @(negedge clk);
        #1;
        checkOutput("busyOddAcks", ackSeen - base, 2);
        checkOutput("busyOddTx", busIf.tx_data, 16'd600);

        // Two extra toggles while busy cancel out.
        base = ackSeen;
        applyStimulus(8'd7, 8'd9);
        repeat (3) @(negedge clk);
        busIf.req = ~busIf.req;
        repeat (2) @(negedge clk);
        busIf.req = ~busIf.req;
        repeat (3 * (W + 3)) @(negedge clk);
        #1;
        checkOutput("busyEvenAcks", ackSeen - base, 1);
        checkOutput("busyEvenTx", busIf.tx_data, 16'd63);

        // Randomized operand pairs, with a reset pulse during one operation.
        for (int i = 0; i < 1000; i++) begin
            a   = W'($urandom());
            b   = W'($urandom());
            sel = $urandom_range(0, 15);
            if (sel == 0) a = '0;
            else if (sel == 1) b = '0;
            else if (sel == 2) a = '1;
            else if (sel == 3) b = '1;

            if (i == 500) begin
                base = ackSeen;
                applyStimulus(a, b);
                repeat (5) @(negedge clk);
                rstn      = 1'b0;
                busIf.req = 1'b0;
                repeat (2) @(negedge clk);
                #1;
                checkOutput("midResetCst", busIf.cst, 2'd0);
                checkOutput("midResetTx", busIf.tx_data, 16'h0000);
                @(negedge clk);
                rstn = 1'b1;
                repeat (W + 4) @(negedge clk);
                #1;
                checkOutput("midResetNoAck", ackSeen - base, 0);
            end

            expProd = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            runOp(a, b, 1'b1, lat, prod);
            checkOutput("randProd", prod, expProd);
            checkOutput("randLat", lat, expLatency(a, b));
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
